// File: rtl/fetch_pkg.sv
// Shared constants for the fetch/phase sequencer: one-hot phase codes, run state, reset PC.
package fetch_pkg;

  typedef enum logic {
    StStop = 1'b0,
    StRun  = 1'b1
  } run_state_e;

  localparam logic [4:0] PH_NONE = 5'b00000;
  localparam logic [4:0] PH_P1   = 5'b00001;
  localparam logic [4:0] PH_P2   = 5'b00010;
  localparam logic [4:0] PH_P3   = 5'b00100;
  localparam logic [4:0] PH_P4   = 5'b01000;
  localparam logic [4:0] PH_P5   = 5'b10000;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/fetch bus between the core and the fetch sequencer.
// imem_ready exists only when FETCH_STALL_EN is defined.
interface fetch_sequencer_if #(
  parameter int unsigned PC_W = 16
) ();

`ifdef FETCH_STALL_EN
  logic            imem_ready;
`endif
  logic            EXEC;
  logic            HALT;
  logic            PC_load;
  logic            taken;
  logic [PC_W-1:0] target;
  logic [15:0]     imem_rdata;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     COMMAND;
  logic [PC_W-1:0] PC;
  logic [4:0]      phase;
  logic            running;

  modport master (
`ifdef FETCH_STALL_EN
    output imem_ready,
`endif
    output EXEC, HALT, PC_load, taken, target, imem_rdata,
    input  imem_addr, COMMAND, PC, phase, running
  );

  modport slave (
`ifdef FETCH_STALL_EN
    input  imem_ready,
`endif
    input  EXEC, HALT, PC_load, taken, target, imem_rdata,
    output imem_addr, COMMAND, PC, phase, running
  );

endinterface

// File: rtl/phase_ring.sv
// One-hot P1..P5 phase ring with STOP/RUN state and a deferred stop request,
// so a stop pulse mid-instruction only takes effect after P5.
module phase_ring
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_exec,
  input  logic       i_halt_p5,
  input  logic       i_advance,
  output logic [4:0] o_phase,
  output logic       o_running
);

  run_state_e r_state, w_state_next;
  logic [4:0] r_phase, w_phase_next;
  logic       r_stop_pending, w_stop_pending_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StStop;
      r_phase        <= PH_NONE;
      r_stop_pending <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_phase        <= w_phase_next;
      r_stop_pending <= w_stop_pending_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_phase_next        = r_phase;
    w_stop_pending_next = r_stop_pending;
    unique case (r_state)
      StStop: begin
        if (i_exec) begin
          w_state_next = StRun;
          w_phase_next = PH_P1;
        end
      end
      StRun: begin
        if (r_phase == PH_P5) begin
          // P5 never stalls; this is the only point where RUN may end.
          if (i_halt_p5 || i_exec || r_stop_pending) begin
            w_state_next        = StStop;
            w_phase_next        = PH_NONE;
            w_stop_pending_next = 1'b0;
          end else begin
            w_phase_next = PH_P1;
          end
        end else begin
          if (i_exec) w_stop_pending_next = 1'b1;
          if (i_advance) w_phase_next = {r_phase[3:0], 1'b0};
        end
      end
    endcase
  end

  assign o_phase   = r_phase;
  assign o_running = (r_state == StRun);

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle core fetch sequencer: PC and instruction register around the phase ring.
// Optional FETCH_STALL_EN adds imem_ready, which stretches P1 until the fetch completes.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input logic              clk,
  input logic              rst_n,
  fetch_sequencer_if.slave bus
);

  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_command;
  logic [4:0]      w_phase;
  logic            w_running;
  logic            w_advance;
  logic            w_fetch;
  logic            w_branch;

`ifdef FETCH_STALL_EN
  assign w_advance = ~w_phase[0] | bus.imem_ready;
`else
  assign w_advance = 1'b1;
`endif

  assign w_fetch  = w_phase[0] & w_advance;
  assign w_branch = w_phase[4] & bus.PC_load & bus.taken;

  phase_ring u_phase_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_exec    (bus.EXEC),
    .i_halt_p5 (bus.HALT & w_phase[4]),
    .i_advance (w_advance),
    .o_phase   (w_phase),
    .o_running (w_running)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_command <= 16'h0000;
    end else if (w_fetch) begin
      r_command <= bus.imem_rdata;
      r_pc      <= r_pc + PC_W'(1);
    end else if (w_branch) begin
      r_pc <= bus.target;
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.PC        = r_pc;
  assign bus.COMMAND   = r_command;
  assign bus.phase     = w_phase;
  assign bus.running   = w_running;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed test-plan checks plus randomized traffic
// against a phase-number reference model; stall checks when FETCH_STALL_EN is defined.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        exec, halt, pc_load, taken, rdy;
  logic [15:0] target;
  int          n_vec;
  int          n_err;
  bit          chk_en;

  // reference model state: phase number 0 (stopped) or 1..5
  int          m_ph;
  bit          m_pend;
  logic [15:0] m_pc;
  logic [15:0] m_cmd;

  fetch_sequencer_if #(.PC_W(16)) b  ();
  fetch_sequencer_if #(.PC_W(16)) bw ();

  function automatic logic [15:0] imem(input logic [15:0] a);
    return a * 16'h3B1D + 16'hC123;
  endfunction

  assign b.EXEC       = exec;
  assign b.HALT       = halt;
  assign b.PC_load    = pc_load;
  assign b.taken      = taken;
  assign b.target     = target;
  assign b.imem_rdata = imem(b.imem_addr);
  assign bw.EXEC       = exec;
  assign bw.HALT       = halt;
  assign bw.PC_load    = pc_load;
  assign bw.taken      = taken;
  assign bw.target     = target;
  assign bw.imem_rdata = imem(bw.imem_addr);
`ifdef FETCH_STALL_EN
  assign b.imem_ready  = rdy;
  assign bw.imem_ready = rdy;
`endif

  fetch_sequencer #(.PC_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  fetch_sequencer #(.PC_W(16), .RESET_PC(16'hFFFF)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_pend = 0; m_pc = 16'h0000; m_cmd = 16'h0000;
    end else if (m_ph == 0) begin
      if (exec) m_ph = 1;
    end else if (m_ph == 5) begin
      if (pc_load && taken) m_pc = target;
      if (halt || exec || m_pend) begin
        m_ph = 0; m_pend = 0;
      end else begin
        m_ph = 1;
      end
    end else begin
      bit adv;
`ifdef FETCH_STALL_EN
      adv = (m_ph != 1) || rdy;
`else
      adv = 1;
`endif
      if (exec) m_pend = 1;
      if (m_ph == 1 && adv) begin
        m_cmd = imem(m_pc);
        m_pc  = m_pc + 16'd1;
      end
      if (adv) m_ph = m_ph + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0] exp_ph;
      exp_ph = (m_ph == 0) ? 5'b0 : 5'(1 << (m_ph - 1));
      chk("model_pc", 32'(b.PC), 32'(m_pc));
      chk("model_imem_addr", 32'(b.imem_addr), 32'(m_pc));
      chk("model_command", 32'(b.COMMAND), 32'(m_cmd));
      chk("model_phase", 32'(b.phase), 32'(exp_ph));
      chk("model_running", 32'(b.running), 32'(m_ph != 0));
    end
  end

  initial begin
    n_vec = 0; n_err = 0; chk_en = 0;
    rst_n = 0; exec = 0; halt = 0; pc_load = 0; taken = 0; target = 0; rdy = 1;
    repeat (2) @(negedge clk);
    chk("reset_pc", 32'(b.PC), 32'h0);
    chk("reset_command", 32'(b.COMMAND), 32'h0);
    chk("reset_phase", 32'(b.phase), 32'h0);
    chk("reset_running", 32'(b.running), 32'h0);
    chk("reset_pc_wrapdut", 32'(bw.PC), 32'hFFFF);
    chk_en = 1;
    rst_n  = 1;

    @(negedge clk); exec = 1;
    @(negedge clk); exec = 0;
    chk("start_phase", 32'(b.phase), 32'h01);
    chk("start_running", 32'(b.running), 32'h1);
    @(negedge clk);
    chk("p2_phase", 32'(b.phase), 32'h02);
    chk("p2_command", 32'(b.COMMAND), 32'hC123);
    chk("p2_pc", 32'(b.PC), 32'h1);
    chk("wrap_pc", 32'(bw.PC), 32'h0);
    @(negedge clk); chk("p3_phase", 32'(b.phase), 32'h04);
    @(negedge clk); chk("p4_phase", 32'(b.phase), 32'h08);
    pc_load = 1; taken = 1; target = 16'h0040;
    @(negedge clk);
    chk("p5_phase", 32'(b.phase), 32'h10);
    chk("branch_ignored_p4", 32'(b.PC), 32'h1);
    @(negedge clk);
    chk("branch_taken_addr", 32'(b.imem_addr), 32'h0040);
    chk("walk_back_p1", 32'(b.phase), 32'h01);
    pc_load = 0; taken = 0; target = 0;
    repeat (4) @(negedge clk);
    chk("p5_pc_41", 32'(b.PC), 32'h41);
    pc_load = 1; taken = 0; target = 16'h0077;
    @(negedge clk);
    chk("branch_not_taken", 32'(b.PC), 32'h41);
    pc_load = 0; target = 0;
    repeat (2) @(negedge clk);
    halt = 1;
    @(negedge clk); halt = 0;
    chk("halt_p3_running", 32'(b.running), 32'h1);
    chk("halt_p3_phase", 32'(b.phase), 32'h08);
    @(negedge clk); halt = 1;
    @(negedge clk); halt = 0;
    chk("halt_running", 32'(b.running), 32'h0);
    chk("halt_phase", 32'(b.phase), 32'h0);
    chk("halt_pc", 32'(b.PC), 32'h42);
    @(negedge clk);
    chk("stopped_stays", 32'(b.phase), 32'h0);
    exec = 1;
    @(negedge clk); exec = 0;
    chk("restart_addr", 32'(b.imem_addr), 32'h42);
    @(negedge clk); exec = 1;
    @(negedge clk); exec = 0;
    chk("stopreq_p3", 32'(b.phase), 32'h04);
    repeat (2) @(negedge clk);
    chk("stopreq_p5", 32'(b.phase), 32'h10);
    @(negedge clk);
    chk("stopreq_phase", 32'(b.phase), 32'h0);
    chk("stopreq_running", 32'(b.running), 32'h0);
    chk("stopreq_pc", 32'(b.PC), 32'h43);
    exec = 1;
    @(negedge clk); exec = 0;
    chk("resume_addr", 32'(b.imem_addr), 32'h43);
    repeat (3) @(negedge clk);
    chk("pre_reset_p4", 32'(b.phase), 32'h08);
    #2 rst_n = 0;
    #1;
    chk("async_pc", 32'(b.PC), 32'h0);
    chk("async_command", 32'(b.COMMAND), 32'h0);
    chk("async_phase", 32'(b.phase), 32'h0);
    chk("async_running", 32'(b.running), 32'h0);
    @(negedge clk); rst_n = 1;

`ifdef FETCH_STALL_EN
    @(negedge clk); exec = 1; rdy = 0;
    @(negedge clk); exec = 0;
    chk("stall_p1_enter", 32'(b.phase), 32'h01);
    repeat (2) begin
      @(negedge clk);
      chk("stall_p1_hold", 32'(b.phase), 32'h01);
      chk("stall_no_capture", 32'(b.COMMAND), 32'h0);
    end
    @(negedge clk);
    chk("stall_p1_hold3", 32'(b.phase), 32'h01);
    chk("stall_pc_held", 32'(b.PC), 32'h0);
    rdy = 1;
    @(negedge clk);
    chk("stall_release_phase", 32'(b.phase), 32'h02);
    chk("stall_release_cmd", 32'(b.COMMAND), 32'hC123);
    chk("stall_release_pc", 32'(b.PC), 32'h1);
`endif

    repeat (3000) begin
      @(negedge clk);
      exec    = ($urandom_range(0, 11) == 0);
      halt    = ($urandom_range(0, 9) == 0);
      pc_load = ($urandom_range(0, 2) == 0);
      taken   = ($urandom_range(0, 1) == 0);
      target  = 16'($urandom);
`ifdef FETCH_STALL_EN
      rdy     = ($urandom_range(0, 3) != 0);
`endif
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
